yuv_frame_reader: RTL and testbench
===================================

# yuv_frame_reader

Streams one stored YUV420 planar frame out of a synchronous-read BRAM as a byte stream with valid/ready flow control, in file order: full Y plane, then U plane, then V plane. It sits directly upstream of the frame dump/compare stage: its output byte sequence is what gets written to the binary frame file and compared byte-for-byte against the golden file. At 1280x720 one frame is 1382400 bytes.

## Interface
- WIDTH, 1280, luma pixels per line (even, ≥2)
- HEIGHT, 720, luma lines (even, ≥2)
- ADDR_W, 25, BRAM byte-address width
- Y_BASE, 0, BRAM byte address of the first Y byte
- U_BASE, WIDTH*HEIGHT, BRAM byte address of the first U byte
- V_BASE, WIDTH*HEIGHT*5/4, BRAM byte address of the first V byte
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame read; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final byte is accepted
- ram_en  out  1  BRAM read enable
- ram_addr  out  ADDR_W  BRAM read address
- ram_rdata  in  8  BRAM read data, valid exactly one cycle after ram_en
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_data  out  8  output byte
- m_plane  out  2  plane of m_data: 0=Y, 1=U, 2=V
- m_last  out  1  high on the final byte of the frame (last V byte)
- checksum  out  32  only with YUV_RD_CHECKSUM_EN; see Configuration

## Operation
- FSM states: IDLE, RD_Y, RD_U, RD_V, DRAIN.
- IDLE: start=1 → RD_Y, load plane counter to 0, busy=1.
- Plane lengths: Y = WIDTH*HEIGHT; U = V = WIDTH*HEIGHT/4. Read address = plane base + plane counter.
- In RD_*: issue one read (ram_en=1) per cycle when the output buffer will have room, i.e. the number of stored bytes plus in-flight reads is < 2. On the last read of a plane, the counter resets to 0 and the FSM advances RD_Y→RD_U→RD_V→DRAIN.
- DRAIN: no reads. When the m_last byte is accepted → IDLE, with done=1 for one cycle and busy=0.
- Output buffer: a 2-entry skid/FIFO holding {data, plane, last}. The plane and last tags travel with the read through a one-stage tag pipeline aligned to ram_rdata. Bytes are never dropped or duplicated under any m_ready pattern.
- Reset: all state returns to IDLE and the buffer is emptied. On the cycle after rst is sampled, busy, done, ram_en, m_valid, m_last, and checksum are 0, and ram_addr, m_data, and m_plane are 0. rst mid-frame abandons the frame with no done pulse, and in-flight read data is discarded.
- start in the same cycle as done: ignored. A new start is honoured only in IDLE.

## Timing
- Start accepted at edge 0 → ram_en=1 with ram_addr=Y_BASE from edge 1 → m_valid=1 with the first Y byte from edge 2.
- With m_ready held 1, the throughput is 1 byte/clk with no bubbles, including across plane changes. A full frame takes N+2 cycles from start to the last acceptance, where N = WIDTH*HEIGHT*3/2. done is asserted the cycle after the last acceptance.
- m_data, m_plane, and m_last stay stable while m_valid=1 and m_ready=0.

## Configuration
- YUV_RD_CHECKSUM_EN defined: the checksum port exists. It is a 32-bit wrapping sum of all accepted bytes of the current frame, cleared when start is accepted, and held after done until the next start.
- Undefined: the checksum port and its adder are absent; all other behaviour is identical.

## Structure
- Shared package yuv_pkg: plane enum (PLANE_Y/U/V), state enum, and helper constants for plane sizes and frame size (Y_SIZE, C_SIZE, FRAME_SIZE) as functions of WIDTH/HEIGHT.
- One sub-module: yuv_skid_buf, the 2-entry valid/ready buffer carrying {data, plane, last}.

## Test plan
- WIDTH=4, HEIGHT=2, bases 0/8/10, BRAM[i]=i, m_ready=1 → 12 bytes 0x00..0x0B. m_plane is 0 for bytes 0–7, 1 for bytes 8–9, and 2 for bytes 10–11. m_last is high only on 0x0B, first m_valid appears 2 cycles after start, and done is pulsed at cycle 14.
- Same setup, non-contiguous bases Y_BASE=0x100, U_BASE=0x200, V_BASE=0x300 → ram_addr sequence 0x100–0x107, 0x200–0x201, 0x300–0x301.
- m_ready random at 30% → the output sequence is identical to the first scenario, with no drops or duplicates, and the output is stable while stalled.
- m_ready=0 for 20 cycles after start → at most 2 reads are issued, then resuming gives the correct sequence.
- rst asserted after the 5th accepted byte → outputs are 0 the next cycle with no done pulse. A fresh start then restarts from 0x00.
- start pulsed mid-frame and in the done cycle → both ignored. Full 1280x720 run with checksum enabled → 1382400 bytes output, and checksum equals the software sum.

Source files
------------

// File: rtl/yuv_pkg.sv
// Shared types and size helpers for the YUV420 planar frame reader.
//   plane_e  : plane tag carried with every output byte (0=Y, 1=U, 2=V)
//   state_e  : reader FSM states
//   beat_t   : one buffered output byte with its plane and last tags
//   y_size / c_size / frame_size : plane and frame byte counts for a WIDTH x HEIGHT frame
package yuv_pkg;

  typedef enum logic [1:0] {
    PLANE_Y = 2'd0,
    PLANE_U = 2'd1,
    PLANE_V = 2'd2
  } plane_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_Y,
    RD_U,
    RD_V,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    plane_e     plane;
    logic       last;
  } beat_t;

  function automatic int unsigned y_size(int unsigned w, int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned c_size(int unsigned w, int unsigned h);
    return (w * h) / 4;
  endfunction

  function automatic int unsigned frame_size(int unsigned w, int unsigned h);
    return (w * h * 3) / 2;
  endfunction

endpackage

// File: rtl/yuv_skid_buf.sv
// Two-entry output buffer with fall-through for the frame reader.
// The upstream side has no backpressure: the reader only issues a read when the
// byte it returns is guaranteed a slot. When empty, an arriving byte is presented
// on the output in the same cycle; otherwise bytes leave in arrival order.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (empties the buffer)
//   i_valid, i_beat     : arriving byte {data, plane, last}
//   o_valid, o_beat     : head byte; o_beat is all-zero while o_valid=0
//   i_ready             : downstream accept
//   o_count             : number of stored entries (0..2), excluding the arriving byte
module yuv_skid_buf
  import yuv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  beat_t      i_beat,
  output logic       o_valid,
  output beat_t      o_beat,
  input  logic       i_ready,
  output logic [1:0] o_count
);

  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_has;
  logic w_pop;
  logic w_store;
  logic w_deq;

  always_comb begin
    w_has   = (r_count != 2'd0);
    o_valid = w_has | i_valid;
    if (w_has) begin
      o_beat = r_mem[r_rd_ptr];
    end else if (i_valid) begin
      o_beat = i_beat;
    end else begin
      o_beat = '0;
    end
    w_pop   = o_valid & i_ready;
    // A byte that passes straight through an empty buffer is never stored.
    w_store = i_valid & ~(~w_has & w_pop);
    w_deq   = w_pop & w_has;
    o_count = r_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_store) begin
        r_mem[r_wr_ptr] <= i_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_store) - 2'(w_deq);
    end
  end

endmodule

// File: rtl/yuv_frame_reader.sv
// Streams one YUV420 planar frame (Y plane, then U, then V) out of a
// synchronous-read BRAM as a valid/ready byte stream.
// Optional feature: define YUV_RD_CHECKSUM_EN to add the 32-bit checksum port
// (wrapping sum of the accepted bytes of the current frame).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle frame request, honoured only when idle
//   busy, done          : frame in progress / one-cycle completion pulse
//   ram_en, ram_addr    : BRAM read request; ram_rdata returns one cycle later
//   m_valid, m_ready    : output handshake
//   m_data, m_plane     : output byte and its plane (0=Y, 1=U, 2=V)
//   m_last              : final byte of the frame
//   checksum            : running byte sum (YUV_RD_CHECKSUM_EN only)
module yuv_frame_reader
  import yuv_pkg::*;
#(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 720,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned Y_BASE = 0,
  parameter int unsigned U_BASE = WIDTH * HEIGHT,
  parameter int unsigned V_BASE = (WIDTH * HEIGHT * 5) / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic [1:0]        m_plane,
  output logic              m_last
`ifdef YUV_RD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int unsigned Y_SIZE = y_size(WIDTH, HEIGHT);
  localparam int unsigned C_SIZE = c_size(WIDTH, HEIGHT);

  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(Y_SIZE - 1);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(C_SIZE - 1);
  localparam logic [ADDR_W-1:0] Y_B    = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0] U_B    = ADDR_W'(U_BASE);
  localparam logic [ADDR_W-1:0] V_B    = ADDR_W'(V_BASE);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_pend;
  plane_e            r_tag_plane;
  logic              r_tag_last;
  logic              r_done;

  logic              w_rd_state;
  logic              w_plane_end;
  logic              w_room;
  logic              w_issue;
  logic              w_pop;
  logic              w_start_ok;
  plane_e            w_issue_plane;
  logic              w_issue_last;

  beat_t             w_in_beat;
  beat_t             w_out_beat;
  logic              w_out_valid;
  logic [1:0]        w_count;

  // ---------------------------------------------------------------------------
  // Shared decode used by both the next-state and output processes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_state  = (r_state == RD_Y) || (r_state == RD_U) || (r_state == RD_V);
    w_pop       = w_out_valid & m_ready;
    // A start arriving alongside done is dropped even though the FSM is already idle.
    w_start_ok  = (r_state == IDLE) & start & ~r_done;
    // Issue only if the returning byte is sure to fit: stored + in flight,
    // minus the byte leaving this cycle, must stay below the two buffer slots.
    w_room      = (({1'b0, w_count} + 3'(r_pend) - 3'(w_pop)) < 3'd2);
    w_issue     = w_rd_state & w_room;
    case (r_state)
      RD_Y:    w_plane_end = (r_cnt == Y_LAST);
      RD_U:    w_plane_end = (r_cnt == C_LAST);
      RD_V:    w_plane_end = (r_cnt == C_LAST);
      default: w_plane_end = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_next = RD_Y;
      RD_Y:    if (w_issue && w_plane_end) w_state_next = RD_U;
      RD_U:    if (w_issue && w_plane_end) w_state_next = RD_V;
      RD_V:    if (w_issue && w_plane_end) w_state_next = DRAIN;
      DRAIN:   if (w_pop && w_out_beat.last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = (r_state != IDLE);
    ram_en        = w_issue;
    ram_addr      = '0;
    w_issue_plane = PLANE_Y;
    w_issue_last  = 1'b0;
    case (r_state)
      RD_Y: begin
        ram_addr      = Y_B + r_cnt;
        w_issue_plane = PLANE_Y;
      end
      RD_U: begin
        ram_addr      = U_B + r_cnt;
        w_issue_plane = PLANE_U;
      end
      RD_V: begin
        ram_addr      = V_B + r_cnt;
        w_issue_plane = PLANE_V;
        w_issue_last  = w_plane_end;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Plane counter, tag pipeline aligned to ram_rdata, done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_tag_plane <= PLANE_Y;
      r_tag_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) & w_pop & w_out_beat.last;
      r_pend <= w_issue;
      if (w_issue) begin
        r_tag_plane <= w_issue_plane;
        r_tag_last  <= w_issue_last;
      end
      if (w_start_ok) begin
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= w_plane_end ? '0 : r_cnt + ADDR_W'(1);
      end
    end
  end

  assign done = r_done;

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  assign w_in_beat = '{data: ram_rdata, plane: r_tag_plane, last: r_tag_last};

  yuv_skid_buf u_skid_buf (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_pend),
    .i_beat  (w_in_beat),
    .o_valid (w_out_valid),
    .o_beat  (w_out_beat),
    .i_ready (m_ready),
    .o_count (w_count)
  );

  assign m_valid = w_out_valid;
  assign m_data  = w_out_beat.data;
  assign m_plane = w_out_beat.plane;
  assign m_last  = w_out_beat.last;

`ifdef YUV_RD_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (w_start_ok) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + 32'(w_out_beat.data);
    end
  end

  assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_yuv_frame_reader.sv
// Bench for yuv_frame_reader: two instances (contiguous and non-contiguous plane
// bases) share start/m_ready and are checked against a frame-order model.
module tb_yuv_frame_reader;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 12;
  localparam int Y  = W * H;
  localparam int C  = (W * H) / 4;
  localparam int N  = Y + 2 * C;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          m_ready;
  logic          busy      [2];
  logic          done      [2];
  logic          ram_en    [2];
  logic          m_valid   [2];
  logic          m_last    [2];
  logic [AW-1:0] ram_addr  [2];
  logic [7:0]    ram_rdata [2];
  logic [7:0]    m_data    [2];
  logic [1:0]    m_plane   [2];
`ifdef YUV_RD_CHECKSUM_EN
  logic [31:0]   cs        [2];
`endif

  logic [7:0] mem [0:4095];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  yuv_frame_reader #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .Y_BASE(0), .U_BASE(8), .V_BASE(10)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .done(done[0]),
    .ram_en(ram_en[0]), .ram_addr(ram_addr[0]), .ram_rdata(ram_rdata[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
    .m_plane(m_plane[0]), .m_last(m_last[0])
`ifdef YUV_RD_CHECKSUM_EN
    , .checksum(cs[0])
`endif
  );

  yuv_frame_reader #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .Y_BASE('h100), .U_BASE('h200), .V_BASE('h300)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .done(done[1]),
    .ram_en(ram_en[1]), .ram_addr(ram_addr[1]), .ram_rdata(ram_rdata[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
    .m_plane(m_plane[1]), .m_last(m_last[1])
`ifdef YUV_RD_CHECKSUM_EN
    , .checksum(cs[1])
`endif
  );

  // Synchronous-read BRAM models: data valid the cycle after ram_en.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_en[d]) ram_rdata[d] <= mem[ram_addr[d]];
    end
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  // Frame order model: byte k of the frame comes from plane base + offset in plane.
  function automatic int unsigned exp_addr(input int d, input int k);
    int unsigned b [3];
    if (d == 0) b = '{0, 8, 10};
    else        b = '{'h100, 'h200, 'h300};
    if (k >= N) return 32'hFFFF_FFFF;
    if (k < Y) return b[0] + k;
    if (k < Y + C) return b[1] + (k - Y);
    return b[2] + (k - Y - C);
  endfunction

  function automatic int exp_plane(input int k);
    if (k < Y) return 0;
    if (k < Y + C) return 1;
    return 2;
  endfunction

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk(tag, d, {5'b0, busy[d], done[d], ram_en[d], m_valid[d], m_last[d], m_plane[d],
                   m_data[d], ram_addr[d]}, 32'd0);
`ifdef YUV_RD_CHECKSUM_EN
      chk({tag, "_cs"}, d, cs[d], 32'd0);
`endif
    end
  endtask

  // One frame request. Cycle 0 carries the start pulse; cycle c spans edge c..c+1.
  //   pct         : m_ready probability in percent
  //   stall       : m_ready forced low through this cycle
  //   abort_after : assert rst after this many accepted bytes (0 = never)
  //   poke        : pulse start mid-frame and in the done cycle
  task automatic run_frame(input int pct, input int stall, input int abort_after,
                           input bit poke);
    int          acc [2]        = '{0, 0};
    int          rd [2]         = '{0, 0};
    int          first_v [2]    = '{-1, -1};
    int          last_acc [2]   = '{-100, -100};
    bit          prev_stall [2] = '{1'b0, 1'b0};
    logic [10:0] prev_out [2];
    int unsigned sum [2]        = '{0, 0};
    int          abort_c        = -1;
    bit          finished       = 1'b0;
    bit          busy_exp;
    bit          done_exp;

    @(posedge clk); #1;
    start   = 1'b1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c < 400 && !finished; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      start   = poke && (c == 5 || (acc[0] == N && c == last_acc[0] + 1));
      m_ready = (c <= stall) ? 1'b0 : ($urandom_range(0, 99) < pct);
      if (abort_c >= 0 && c == abort_c + 1) rst = 1'b0;
      if (abort_after > 0 && abort_c < 0 && acc[0] == abort_after) begin
        rst     = 1'b1;
        m_ready = 1'b0;
        abort_c = c;
      end
      @(negedge clk);

      if (abort_c >= 0) begin
        if (c == abort_c + 1) check_idle("reset_mid_frame");
        if (c > abort_c + 1) begin
          for (int d = 0; d < 2; d++) chk("no_done_after_reset", d, done[d], 0);
        end
        if (c >= abort_c + 6) finished = 1'b1;
        continue;
      end

      for (int d = 0; d < 2; d++) begin
        if (prev_stall[d]) begin
          chk("stall_hold", d, {m_valid[d], m_plane[d], m_last[d], m_data[d]},
              {1'b1, prev_out[d]});
        end
        prev_stall[d] = m_valid[d] && !m_ready;
        prev_out[d]   = {m_plane[d], m_last[d], m_data[d]};
        if (m_valid[d] && first_v[d] < 0) first_v[d] = c;

        busy_exp = (acc[d] < N);
        done_exp = (acc[d] == N) && (c == last_acc[d] + 1);
        chk("busy", d, busy[d], busy_exp);
        chk("done", d, done[d], done_exp);

        if (ram_en[d]) begin
          chk("rd_addr", d, ram_addr[d], exp_addr(d, rd[d]));
          rd[d]++;
        end
        if (stall > 0 && c == stall) chk("stall_reads_le2", d, rd[d] <= 2, 1);

        if (m_valid[d] && m_ready) begin
          if (acc[d] >= N) begin
            chk("extra_byte", d, acc[d], N - 1);
          end else begin
            chk("data", d, m_data[d], mem[exp_addr(d, acc[d])]);
            chk("plane", d, m_plane[d], exp_plane(acc[d]));
            chk("last", d, m_last[d], acc[d] == N - 1);
          end
          sum[d]      += m_data[d];
          last_acc[d] = c;
          acc[d]++;
        end
      end
      if (acc[0] == N && acc[1] == N && c >= last_acc[0] + 4 && c >= last_acc[1] + 4)
        finished = 1'b1;
    end
    start   = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b0;

    if (!finished) begin
      chk("frame_timeout", 0, 0, 1);
    end else if (abort_after == 0) begin
      for (int d = 0; d < 2; d++) begin
        chk("bytes", d, acc[d], N);
        chk("reads", d, rd[d], N);
        chk("first_valid_cycle", d, first_v[d], 2);
        if (pct == 100 && stall == 0) chk("last_accept_cycle", d, last_acc[d], N + 1);
`ifdef YUV_RD_CHECKSUM_EN
        chk("checksum", d, cs[d], sum[d]);
`endif
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = (i < 16) ? 8'(i) : 8'($urandom_range(0, 255));
    end
    rst     = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(100, 0, 0, 1'b0);   // full rate, exact timing
    run_frame(30, 0, 0, 1'b0);    // sparse ready
    run_frame(100, 20, 0, 1'b0);  // long stall right after start
    run_frame(60, 0, 5, 1'b0);    // reset after the 5th accepted byte
    run_frame(100, 0, 0, 1'b1);   // fresh frame; starts mid-frame and at done ignored
    run_frame(50, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
